// File: rtl/occupancy_map_streamer_if.sv
// Control, RAM read port and output stream bundle for occupancy_map_streamer.
// master = the streamer, slave = the surrounding system (controller, RAM, sink).
interface occupancy_map_streamer_if #(
    parameter int DATA_WIDTH = 8,
    parameter int MAP_WIDTH  = 256,
    parameter int MAP_HEIGHT = 128
);
    localparam int XW = $clog2(MAP_WIDTH);
    localparam int YW = $clog2(MAP_HEIGHT);
    localparam int AW = XW + YW;

    logic                  start;
    logic                  abort;
    logic [XW-1:0]         win_x0;
    logic [YW-1:0]         win_y0;
    logic [XW:0]           win_w;
    logic [YW:0]           win_h;
    logic                  busy;
    logic                  done;
    logic                  mem_rd_en;
    logic [AW-1:0]         mem_addr;
    logic [DATA_WIDTH-1:0] mem_rd_data;
    logic [DATA_WIDTH-1:0] out_data;
    logic                  out_valid;
    logic                  out_ready;
    logic                  out_last;

    modport master (
        input  start, abort, win_x0, win_y0, win_w, win_h, mem_rd_data, out_ready,
        output busy, done, mem_rd_en, mem_addr, out_data, out_valid, out_last
    );

    modport slave (
        output start, abort, win_x0, win_y0, win_w, win_h, mem_rd_data, out_ready,
        input  busy, done, mem_rd_en, mem_addr, out_data, out_valid, out_last
    );
endinterface

// File: rtl/occupancy_map_streamer.sv
// Scans a clipped window of the occupancy RAM and streams cells out over valid/ready.
// Optional STREAM_CHECKSUM_EN appends a 16-bit sum of the streamed cells.
module occupancy_map_streamer #(
    parameter int DATA_WIDTH   = 8,
    parameter int MAP_WIDTH    = 256,
    parameter int MAP_HEIGHT   = 128,
    parameter int READ_LATENCY = 1
) (
    input  logic                     clock,
    input  logic                     reset_n,
    occupancy_map_streamer_if.master bus
);
    localparam int XW    = $clog2(MAP_WIDTH);
    localparam int YW    = $clog2(MAP_HEIGHT);
    localparam int AW    = XW + YW;
    localparam int NW    = AW + 1;
    localparam int DEPTH = READ_LATENCY + 1;
    localparam int CW    = $clog2(DEPTH + 1);
    localparam int PW    = $clog2(DEPTH);

`ifdef STREAM_CHECKSUM_EN
    localparam int NB  = (16 + DATA_WIDTH - 1) / DATA_WIDTH;
    localparam int SBW = $clog2(NB + 1);
    typedef enum logic [2:0] {IDLE, SCAN, DRAIN, SUM, DONE} state_e;
`else
    typedef enum logic [1:0] {IDLE, SCAN, DRAIN, DONE} state_e;
`endif

    state_e                  state_q;
    logic                    busy_q, done_q;
    logic [XW-1:0]           x_q, x0_q, xend_q;
    logic [YW-1:0]           y_q, yend_q;
    logic [NW-1:0]           left_q;
    logic [CW-1:0]           cnt_q, fcnt_q;
    logic [PW-1:0]           wr_ptr_q, rd_ptr_q;
    logic [READ_LATENCY-1:0] vld_pipe_q;
    logic [DATA_WIDTH-1:0]   fifo_q [DEPTH];

    logic [XW:0]           room_x, eff_w;
    logic [YW:0]           room_y, eff_h;
    logic [XW-1:0]         xend_d;
    logic [YW-1:0]         yend_d;
    logic [NW-1:0]         total_d;
    logic                  ret_vld, fifo_empty, head_vld, rd_en, xfer, push, pop, last_cell;
    logic [DATA_WIDTH-1:0] head_data;

    // Window clipping against the map edge, evaluated on the start cycle.
    always_comb begin
        room_x  = (XW+1)'(MAP_WIDTH) - {1'b0, bus.win_x0};
        room_y  = (YW+1)'(MAP_HEIGHT) - {1'b0, bus.win_y0};
        eff_w   = (bus.win_w < room_x) ? bus.win_w : room_x;
        eff_h   = (bus.win_h < room_y) ? bus.win_h : room_y;
        xend_d  = bus.win_x0 + eff_w[XW-1:0] - XW'(1);
        yend_d  = bus.win_y0 + eff_h[YW-1:0] - YW'(1);
        total_d = NW'(eff_w) * NW'(eff_h);
    end

    // Returning data bypasses the FIFO when it is empty, so the first beat
    // is visible in the same cycle the RAM presents it.
    assign ret_vld    = vld_pipe_q[READ_LATENCY-1];
    assign fifo_empty = (fcnt_q == '0);
    assign head_vld   = !fifo_empty || ret_vld;
    assign head_data  = fifo_empty ? bus.mem_rd_data : fifo_q[rd_ptr_q];
    assign rd_en      = (state_q == SCAN) && !bus.abort && (cnt_q < CW'(DEPTH));
    assign xfer       = head_vld && bus.out_ready;
    assign push       = ret_vld && !(fifo_empty && bus.out_ready);
    assign pop        = !fifo_empty && bus.out_ready;
    assign last_cell  = (left_q == NW'(1));

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

`ifdef STREAM_CHECKSUM_EN
    logic [15:0]              sum_q;
    logic [SBW-1:0]           sbeat_q;
    logic [NB*DATA_WIDTH-1:0] sum_ext;
    assign sum_ext = (NB*DATA_WIDTH)'(sum_q);
`endif

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            x_q        <= '0;
            y_q        <= '0;
            x0_q       <= '0;
            xend_q     <= '0;
            yend_q     <= '0;
            left_q     <= '0;
            cnt_q      <= '0;
            fcnt_q     <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            vld_pipe_q <= '0;
`ifdef STREAM_CHECKSUM_EN
            sum_q      <= '0;
            sbeat_q    <= '0;
`endif
        end else begin
            done_q     <= 1'b0;
            vld_pipe_q <= READ_LATENCY'({vld_pipe_q, rd_en});
            // Credits cover reads in flight plus cells parked in the FIFO.
            cnt_q      <= cnt_q + CW'(rd_en) - CW'(xfer);
            fcnt_q     <= fcnt_q + CW'(push) - CW'(pop);
            if (push) wr_ptr_q <= ptr_inc(wr_ptr_q);
            if (pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
            if (xfer) begin
                left_q <= left_q - NW'(1);
`ifdef STREAM_CHECKSUM_EN
                sum_q  <= sum_q + 16'(head_data);
`endif
            end
            case (state_q)
                IDLE: begin
                    if (bus.start && !bus.abort) begin
                        busy_q  <= 1'b1;
                        x_q     <= bus.win_x0;
                        y_q     <= bus.win_y0;
                        x0_q    <= bus.win_x0;
                        xend_q  <= xend_d;
                        yend_q  <= yend_d;
                        left_q  <= total_d;
`ifdef STREAM_CHECKSUM_EN
                        sum_q   <= '0;
                        sbeat_q <= '0;
`endif
                        state_q <= (eff_w == '0 || eff_h == '0) ? DONE : SCAN;
                    end
                end
                SCAN, DRAIN: begin
                    if (bus.abort) begin
                        vld_pipe_q <= '0;
                        cnt_q      <= '0;
                        fcnt_q     <= '0;
                        wr_ptr_q   <= '0;
                        rd_ptr_q   <= '0;
                        state_q    <= DONE;
                    end else if (state_q == SCAN) begin
                        if (rd_en) begin
                            if (x_q == xend_q) begin
                                x_q <= x0_q;
                                if (y_q == yend_q) state_q <= DRAIN;
                                else               y_q     <= y_q + YW'(1);
                            end else begin
                                x_q <= x_q + XW'(1);
                            end
                        end
                    end else if (xfer && last_cell) begin
`ifdef STREAM_CHECKSUM_EN
                        state_q <= SUM;
`else
                        state_q <= DONE;
`endif
                    end
                end
`ifdef STREAM_CHECKSUM_EN
                SUM: begin
                    if (bus.out_ready) begin
                        if (sbeat_q == SBW'(NB - 1)) state_q <= DONE;
                        else                         sbeat_q <= sbeat_q + SBW'(1);
                    end
                end
`endif
                DONE: begin
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (push) fifo_q[wr_ptr_q] <= bus.mem_rd_data;
    end

    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.mem_rd_en = rd_en;
    assign bus.mem_addr  = {y_q, x_q};

`ifdef STREAM_CHECKSUM_EN
    assign bus.out_valid = (state_q == SUM) || head_vld;
    assign bus.out_data  = (state_q == SUM) ? sum_ext[sbeat_q*DATA_WIDTH +: DATA_WIDTH]
                         : (head_vld ? head_data : '0);
    assign bus.out_last  = (state_q == SUM) && (sbeat_q == SBW'(NB - 1));
`else
    assign bus.out_valid = head_vld;
    assign bus.out_data  = head_vld ? head_data : '0;
    assign bus.out_last  = head_vld && last_cell;
`endif
endmodule

// File: tb/tb_occupancy_map_streamer.sv
// Randomised bench for occupancy_map_streamer with a RAM model and a window scoreboard.
module tb_occupancy_map_streamer;
  localparam int DW = 8, MW = 256, MH = 128, RL = 3, AW = 15;

  logic clk = 1'b0, rst_n = 1'b0;
  always #5 clk = ~clk;

  occupancy_map_streamer_if #(.DATA_WIDTH(DW), .MAP_WIDTH(MW), .MAP_HEIGHT(MH)) bus ();
  occupancy_map_streamer #(.DATA_WIDTH(DW), .MAP_WIDTH(MW), .MAP_HEIGHT(MH),
                           .READ_LATENCY(RL)) dut (.clock(clk), .reset_n(rst_n), .bus(bus));

  logic [DW-1:0] ram [0:(1<<AW)-1];
  logic [DW-1:0] rd_pipe [RL];
  always @(posedge clk) begin
    rd_pipe[0] <= ram[bus.mem_addr];
    for (int i = 1; i < RL; i++) rd_pipe[i] <= rd_pipe[i-1];
  end
  assign bus.mem_rd_data = rd_pipe[RL-1];

  int n_checks = 0, n_fail = 0;
  logic [DW-1:0] got_q[$], exp_q[$];
  logic [AW-1:0] addr_q[$], exp_addr_q[$];
  int last_pos_q[$];
  int stall_bad, credit_bad, first_cyc, last_cyc, done_cnt, done_cyc;
  bit done_seen;
  logic busy_after;

  // Reference: walk the clipped window row by row and read cells from the RAM image.
  task automatic build_expected(input int x0, input int y0, input int w, input int h);
    int ew, eh, s;
    exp_q.delete(); exp_addr_q.delete();
    ew = (w < MW - x0) ? w : MW - x0;
    eh = (h < MH - y0) ? h : MH - y0;
    s = 0;
    for (int y = y0; y < y0 + eh; y++)
      for (int x = x0; x < x0 + ew; x++) begin
        exp_addr_q.push_back(AW'(y * MW + x));
        exp_q.push_back(ram[y * MW + x]);
        s += int'(ram[y * MW + x]);
      end
`ifdef STREAM_CHECKSUM_EN
    if (ew > 0 && eh > 0) begin
      exp_q.push_back(DW'(s & 'hff));
      exp_q.push_back(DW'((s >> 8) & 'hff));
    end
`endif
  endtask

  // Drives one scan and records what the sink saw; the tests judge the results.
  task automatic run_scan(input int x0, input int y0, input int w, input int h,
                          input int duty, input int max_cyc, input int inject_at);
    bit prev_stall, rdy;
    logic [DW-1:0] prev_data;
    int cyc, outstanding;
    got_q.delete(); last_pos_q.delete(); addr_q.delete();
    stall_bad = 0; credit_bad = 0; first_cyc = -1; last_cyc = -1;
    done_cnt = 0; done_cyc = -1; done_seen = 0;
    prev_stall = 0; prev_data = '0; outstanding = 0;
    @(negedge clk);
    bus.win_x0 = 8'(x0); bus.win_y0 = 7'(y0); bus.win_w = 9'(w); bus.win_h = 8'(h);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    cyc = 1;
    while (!done_seen && cyc < max_cyc) begin
      if (cyc == inject_at) begin
        bus.start = 1'b1; bus.win_x0 = '0; bus.win_y0 = '0; bus.win_w = 9'd1; bus.win_h = 8'd1;
      end else bus.start = 1'b0;
      if (bus.done) begin done_seen = 1; done_cyc = cyc; done_cnt++; end
      if (bus.mem_rd_en) begin
        addr_q.push_back(bus.mem_addr);
        if (outstanding >= RL + 1) credit_bad++;
        outstanding++;
      end
      if (bus.out_valid) begin
        if (first_cyc < 0) first_cyc = cyc;
        if (prev_stall && bus.out_data !== prev_data) stall_bad++;
      end
      rdy = ($urandom_range(99) < duty);
      bus.out_ready = rdy;
      if (bus.out_valid && rdy) begin
        got_q.push_back(bus.out_data);
        if (bus.out_last) last_pos_q.push_back(got_q.size() - 1);
        outstanding--;
        last_cyc = cyc;
      end
      prev_stall = bus.out_valid && !rdy;
      prev_data  = bus.out_data;
      @(negedge clk);
      cyc++;
    end
    bus.start = 1'b0; bus.out_ready = 1'b0;
    busy_after = bus.busy;
    if (bus.done) done_cnt++;
  endtask

  task automatic test_reset;
    repeat (2) @(negedge clk);
    n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
    n_checks++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL reset_done got=%b exp=0", bus.done); end
    n_checks++; if (bus.mem_rd_en !== 1'b0) begin n_fail++; $display("FAIL reset_rd_en got=%b exp=0", bus.mem_rd_en); end
    n_checks++; if (bus.mem_addr !== '0) begin n_fail++; $display("FAIL reset_addr got=%h exp=0", bus.mem_addr); end
    n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got=%b exp=0", bus.out_valid); end
    n_checks++; if (bus.out_last !== 1'b0) begin n_fail++; $display("FAIL reset_last got=%b exp=0", bus.out_last); end
    n_checks++; if (bus.out_data !== '0) begin n_fail++; $display("FAIL reset_data got=%h exp=0", bus.out_data); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_full_map;
    for (int a = 0; a < (1 << AW); a++) ram[a] = DW'(a);
    build_expected(0, 0, MW, MH);
    run_scan(0, 0, MW, MH, 100, 33000, -1);
    n_checks++; if (addr_q.size() != 32768) begin n_fail++; $display("FAIL full_reads got=%0d exp=32768", addr_q.size()); end
    n_checks++; if (got_q.size() != exp_q.size()) begin n_fail++; $display("FAIL full_beats got=%0d exp=%0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      n_checks++;
      if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL full_data[%0d] got=%h exp=%h", i, got_q[i], exp_q[i]); break; end
    end
    n_checks++; if (got_q.size() < 32768 || got_q[32767] !== 8'hFF) begin n_fail++; $display("FAIL full_final_cell size=%0d exp=0xFF at 32767", got_q.size()); end
    n_checks++; if (last_pos_q.size() != 1 || last_pos_q[0] != exp_q.size() - 1) begin n_fail++; $display("FAIL full_last count=%0d exp one at %0d", last_pos_q.size(), exp_q.size() - 1); end
    n_checks++; if (first_cyc != RL + 1) begin n_fail++; $display("FAIL full_first_latency got=%0d exp=%0d", first_cyc, RL + 1); end
    n_checks++; if (last_cyc - first_cyc != exp_q.size() - 1) begin n_fail++; $display("FAIL full_throughput got=%0d exp=%0d", last_cyc - first_cyc, exp_q.size() - 1); end
    n_checks++; if (!done_seen || done_cnt != 1) begin n_fail++; $display("FAIL full_done seen=%0d pulses=%0d exp 1", done_seen, done_cnt); end
    n_checks++; if (busy_after !== 1'b0) begin n_fail++; $display("FAIL full_busy_after got=%b exp=0", busy_after); end
  endtask

  task automatic test_clip;
    for (int a = 0; a < (1 << AW); a++) ram[a] = DW'($urandom);
    build_expected(250, 126, 10, 5);
    run_scan(250, 126, 10, 5, 100, 300, -1);
    n_checks++; if (addr_q.size() != 12) begin n_fail++; $display("FAIL clip_reads got=%0d exp=12", addr_q.size()); end
    n_checks++; if (addr_q.size() < 1 || addr_q[0] !== AW'({7'd126, 8'd250})) begin n_fail++; $display("FAIL clip_first_addr size=%0d", addr_q.size()); end
    n_checks++; if (addr_q.size() < 12 || addr_q[11] !== AW'({7'd127, 8'd255})) begin n_fail++; $display("FAIL clip_last_addr size=%0d", addr_q.size()); end
    for (int i = 0; i < addr_q.size() && i < exp_addr_q.size(); i++) begin
      n_checks++;
      if (addr_q[i] !== exp_addr_q[i]) begin n_fail++; $display("FAIL clip_addr[%0d] got=%h exp=%h", i, addr_q[i], exp_addr_q[i]); end
    end
    n_checks++; if (got_q.size() != exp_q.size()) begin n_fail++; $display("FAIL clip_beats got=%0d exp=%0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      n_checks++;
      if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL clip_data[%0d] got=%h exp=%h", i, got_q[i], exp_q[i]); end
    end
    n_checks++; if (last_pos_q.size() != 1 || last_pos_q[0] != exp_q.size() - 1) begin n_fail++; $display("FAIL clip_last count=%0d", last_pos_q.size()); end
  endtask

  task automatic test_backpressure;
    int x0, y0, w, h;
    for (int it = 0; it < 4; it++) begin
      x0 = $urandom_range(MW - 1); y0 = $urandom_range(MH - 1);
      w = $urandom_range(40, 1); h = $urandom_range(6, 1);
      build_expected(x0, y0, w, h);
      run_scan(x0, y0, w, h, 30, 4000, -1);
      n_checks++; if (got_q.size() != exp_q.size()) begin n_fail++; $display("FAIL bp_beats it=%0d got=%0d exp=%0d", it, got_q.size(), exp_q.size()); end
      for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
        n_checks++;
        if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL bp_data it=%0d [%0d] got=%h exp=%h", it, i, got_q[i], exp_q[i]); end
      end
      n_checks++; if (stall_bad != 0) begin n_fail++; $display("FAIL bp_stall_stable it=%0d changes=%0d exp=0", it, stall_bad); end
      n_checks++; if (credit_bad != 0) begin n_fail++; $display("FAIL bp_credit it=%0d overissues=%0d exp=0", it, credit_bad); end
      n_checks++; if (last_pos_q.size() != 1 || last_pos_q[0] != exp_q.size() - 1) begin n_fail++; $display("FAIL bp_last it=%0d count=%0d", it, last_pos_q.size()); end
      n_checks++; if (!done_seen) begin n_fail++; $display("FAIL bp_done it=%0d got=0 exp=1", it); end
    end
  endtask

  task automatic test_empty_and_busy_start;
    run_scan(10, 10, 0, 5, 100, 40, -1);
    n_checks++; if (addr_q.size() != 0) begin n_fail++; $display("FAIL empty_reads got=%0d exp=0", addr_q.size()); end
    n_checks++; if (first_cyc != -1) begin n_fail++; $display("FAIL empty_valid first valid cycle=%0d exp none", first_cyc); end
    n_checks++; if (!done_seen || done_cnt != 1) begin n_fail++; $display("FAIL empty_done seen=%0d pulses=%0d exp 1", done_seen, done_cnt); end
    build_expected(20, 30, 7, 3);
    run_scan(20, 30, 7, 3, 100, 200, 4);
    n_checks++; if (got_q.size() != exp_q.size()) begin n_fail++; $display("FAIL busy_start_beats got=%0d exp=%0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      n_checks++;
      if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL busy_start_data[%0d] got=%h exp=%h", i, got_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_abort;
    int nbeats, cyc;
    bit saw_last;
    nbeats = 0; cyc = 0; saw_last = 0;
    @(negedge clk);
    bus.win_x0 = '0; bus.win_y0 = '0; bus.win_w = 9'd256; bus.win_h = 8'd128;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0; bus.out_ready = 1'b1;
    while (nbeats < 5 && cyc < 100) begin
      if (bus.out_valid && bus.out_ready) nbeats++;
      if (bus.out_last) saw_last = 1;
      @(negedge clk); cyc++;
    end
    bus.out_ready = 1'b0;
    n_checks++; if (nbeats != 5) begin n_fail++; $display("FAIL abort_prefix beats=%0d exp=5", nbeats); end
    repeat (2) @(negedge clk);
    n_checks++; if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL abort_stalled_valid got=%b exp=1", bus.out_valid); end
    bus.abort = 1'b1;
    @(negedge clk);
    bus.abort = 1'b0;
    n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL abort_valid_drop got=%b exp=0", bus.out_valid); end
    n_checks++; if (bus.mem_rd_en !== 1'b0) begin n_fail++; $display("FAIL abort_rd_en got=%b exp=0", bus.mem_rd_en); end
    n_checks++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL abort_done_early got=%b exp=0", bus.done); end
    if (bus.out_last) saw_last = 1;
    @(negedge clk);
    n_checks++; if (bus.done !== 1'b1) begin n_fail++; $display("FAIL abort_done got=%b exp=1", bus.done); end
    n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL abort_busy got=%b exp=0", bus.busy); end
    n_checks++; if (saw_last) begin n_fail++; $display("FAIL abort_no_last got=1 exp=0"); end
    build_expected(100, 50, 5, 3);
    run_scan(100, 50, 5, 3, 100, 200, -1);
    n_checks++; if (got_q.size() != exp_q.size()) begin n_fail++; $display("FAIL post_abort_beats got=%0d exp=%0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      n_checks++;
      if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL post_abort_data[%0d] got=%h exp=%h", i, got_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_reset_mid_scan;
    int dones;
    dones = 0;
    @(negedge clk);
    bus.win_x0 = 8'd3; bus.win_y0 = 7'd4; bus.win_w = 9'd100; bus.win_h = 8'd20;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0; bus.out_ready = 1'b1;
    repeat (20) @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_checks++; if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0 || bus.mem_rd_en !== 1'b0)
      begin n_fail++; $display("FAIL midreset_outputs valid=%b busy=%b rd=%b exp 0", bus.out_valid, bus.busy, bus.mem_rd_en); end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (6) begin if (bus.done) dones++; @(negedge clk); end
    n_checks++; if (dones != 0) begin n_fail++; $display("FAIL midreset_no_done pulses=%0d exp=0", dones); end
    bus.out_ready = 1'b0;
  endtask

`ifdef STREAM_CHECKSUM_EN
  task automatic test_checksum;
    logic [DW-1:0] want [6];
    want = '{8'h10, 8'h20, 8'h30, 8'h40, 8'hA0, 8'h00};
    ram[7*MW+3] = 8'h10; ram[7*MW+4] = 8'h20; ram[8*MW+3] = 8'h30; ram[8*MW+4] = 8'h40;
    run_scan(3, 7, 2, 2, 100, 100, -1);
    n_checks++; if (got_q.size() != 6) begin n_fail++; $display("FAIL csum_beats got=%0d exp=6", got_q.size()); end
    for (int i = 0; i < got_q.size() && i < 6; i++) begin
      n_checks++;
      if (got_q[i] !== want[i]) begin n_fail++; $display("FAIL csum_data[%0d] got=%h exp=%h", i, got_q[i], want[i]); end
    end
    n_checks++; if (last_pos_q.size() != 1 || last_pos_q[0] != 5) begin n_fail++; $display("FAIL csum_last count=%0d exp one at 5", last_pos_q.size()); end
  endtask
`endif

  initial begin
    bus.start = 1'b0; bus.abort = 1'b0; bus.out_ready = 1'b0;
    bus.win_x0 = '0; bus.win_y0 = '0; bus.win_w = '0; bus.win_h = '0;
    test_reset();
    test_full_map();
    test_clip();
    test_backpressure();
    test_empty_and_busy_start();
    test_abort();
    test_reset_mid_scan();
`ifdef STREAM_CHECKSUM_EN
    test_checksum();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
